// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RV32I writeback stage with load formatting and forwarding port.
// Optional retired-instruction counter is enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DWIDTH-1:0] pc_i,
    input  logic [4:0]        rd_i,
    input  logic              regwren_i,
    input  logic [1:0]        wbsel_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic              memrsp_valid_i,
    input  logic [DWIDTH-1:0] memrsp_data_i,
    input  logic              flush_i,
    output logic [4:0]        rd_o,
    output logic [DWIDTH-1:0] datawb_o,
    output logic              regwren_o,
    output logic              fwd_valid_o,
    output logic [4:0]        fwd_rd_o,
    output logic [DWIDTH-1:0] fwd_data_o,
    output logic              err_o,
    output logic [63:0]       instret_o
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t            state;
    logic              drain;
    logic [4:0]        lat_rd;
    logic              lat_regwren;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_addr_lo;
    logic              hs;
    logic              is_load;
    logic              rsp_use;
    logic [DWIDTH-1:0] wb_data;

    function automatic logic [DWIDTH-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                                   input logic [DWIDTH-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    assign ready_o = rst && (state != WAIT) && !flush_i;
    assign hs      = valid_i && ready_o;
    assign is_load = (wbsel_i == 2'b01);
    // A response arriving while draining belongs to a killed load.
    assign rsp_use = memrsp_valid_i && !drain;

    always_comb begin
        wb_data = '0;
        case (wbsel_i)
            2'b00:   wb_data = alu_res_i;
            2'b01:   wb_data = fmt_load(funct3_i, addr_lo_i, memrsp_data_i);
            2'b10:   wb_data = pc_i + DWIDTH'(4);
            default: wb_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            drain       <= 1'b0;
            err_o       <= 1'b0;
            rd_o        <= '0;
            datawb_o    <= '0;
            regwren_o   <= 1'b0;
            lat_rd      <= '0;
            lat_regwren <= 1'b0;
            lat_funct3  <= '0;
            lat_addr_lo <= '0;
        end else begin
            regwren_o <= 1'b0;
            if (memrsp_valid_i && drain)
                drain <= 1'b0;
            case (state)
                WAIT: begin
                    if (rsp_use) begin
                        state     <= WRITE;
                        rd_o      <= lat_rd;
                        datawb_o  <= fmt_load(lat_funct3, lat_addr_lo, memrsp_data_i);
                        regwren_o <= lat_regwren && (lat_rd != 5'd0);
                    end else if (flush_i) begin
                        state <= IDLE;
                        drain <= 1'b1;
                    end
                end
                default: begin
                    if (hs && (!is_load || rsp_use)) begin
                        state     <= WRITE;
                        rd_o      <= rd_i;
                        datawb_o  <= wb_data;
                        regwren_o <= regwren_i && (rd_i != 5'd0);
                    end else if (hs) begin
                        state       <= WAIT;
                        lat_rd      <= rd_i;
                        lat_regwren <= regwren_i;
                        lat_funct3  <= funct3_i;
                        lat_addr_lo <= addr_lo_i;
                    end else begin
                        state <= IDLE;
                    end
                    if (rsp_use && !(hs && is_load))
                        err_o <= 1'b1;
                end
            endcase
        end
    end

    assign fwd_valid_o = regwren_o;
    assign fwd_rd_o    = rd_o;
    assign fwd_data_o  = datawb_o;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret_q <= '0;
        else if (state == WRITE)
            instret_q <= instret_q + 64'd1;
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] pc_i = '0;
    logic [4:0]  rd_i = '0;
    logic        regwren_i = 1'b0;
    logic [1:0]  wbsel_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [1:0]  addr_lo_i = '0;
    logic [31:0] alu_res_i = '0;
    logic        memrsp_valid_i = 1'b0;
    logic [31:0] memrsp_data_i = '0;
    logic        flush_i = 1'b0;
    logic [4:0]  rd_o;
    logic [31:0] datawb_o;
    logic        regwren_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        err_o;
    logic [63:0] instret_o;

    int          tests = 0;
    int          fails = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [63:0] exp_instret = '0;

    writeback_stage #(.DWIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
        .rd_i(rd_i), .regwren_i(regwren_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i),
        .addr_lo_i(addr_lo_i), .alu_res_i(alu_res_i), .memrsp_valid_i(memrsp_valid_i),
        .memrsp_data_i(memrsp_data_i), .flush_i(flush_i), .rd_o(rd_o), .datawb_o(datawb_o),
        .regwren_o(regwren_o), .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o),
        .fwd_data_o(fwd_data_o), .err_o(err_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] instret_exp(input logic [63:0] n);
`ifdef WB_RETIRE_COUNT_EN
        return n;
`else
        return 64'd0 & n;
`endif
    endfunction

    task automatic send(input logic [1:0] ws, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [4:0] rd, input logic wren, input logic [31:0] alu,
                        input logic [31:0] pc, input logic rv, input logic [31:0] rdat);
        int n;
        @(negedge clk);
        valid_i = 1'b1; wbsel_i = ws; funct3_i = f3; addr_lo_i = lo; rd_i = rd;
        regwren_i = wren; alu_res_i = alu; pc_i = pc;
        memrsp_valid_i = rv; memrsp_data_i = rdat;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: ready_o %b expected 1", ready_o);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        memrsp_valid_i = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] d);
        @(negedge clk);
        memrsp_valid_i = 1'b1;
        memrsp_data_i = d;
        @(posedge clk);
        #1;
        memrsp_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && regwren_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: rd %0d data %h, none expected", rd_o, datawb_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rd_o, datawb_o} !== mon_e || !fwd_valid_o || {fwd_rd_o, fwd_data_o} !== mon_e) begin
                    fails++;
                    $display("FAIL write: rd %0d data %h fwd %b/%0d/%h expected rd %0d data %h",
                             rd_o, datawb_o, fwd_valid_o, fwd_rd_o, fwd_data_o, mon_e[36:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #12;
        chk("reset_ready", ready_o, 0);
        chk("reset_outs", {rd_o, datawb_o, regwren_o, fwd_valid_o, fwd_rd_o, fwd_data_o, err_o}, 0);
        chk("reset_instret", instret_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // ALU op rd=5
        exp_q.push_back({5'd5, 32'h1234});
        send(2'b00, 3'b000, 2'd0, 5'd5, 1'b1, 32'h1234, 32'h100, 1'b0, 32'h0);
        exp_instret++;
        @(negedge clk);
        chk("alu_pulse", regwren_o, 1);
        @(negedge clk);
        chk("alu_pulse_end", regwren_o, 0);

        // LB addr_lo=2, response three cycles after accept
        exp_q.push_back({5'd7, 32'hFFFFFF80});
        send(2'b01, 3'b000, 2'd2, 5'd7, 1'b1, 32'h0, 32'h104, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_ready_low", ready_o, 0);
            if (i == 2) begin
                memrsp_valid_i = 1'b1;
                memrsp_data_i = 32'h00800000;
            end
        end
        @(posedge clk);
        #1;
        memrsp_valid_i = 1'b0;
        exp_instret++;
        chk("lb_write_pulse", regwren_o, 1);

        // LHU addr_lo=3 with response in the accept cycle
        exp_q.push_back({5'd8, 32'h0000BEEF});
        send(2'b01, 3'b101, 2'd3, 5'd8, 1'b1, 32'h0, 32'h108, 1'b1, 32'hBEEF0000);
        exp_instret++;

        // JAL-style PC+4 wrap, then the same with rd=0
        exp_q.push_back({5'd1, 32'h0});
        send(2'b10, 3'b000, 2'd0, 5'd1, 1'b1, 32'h0, 32'hFFFFFFFC, 1'b0, 32'h0);
        exp_instret++;
        send(2'b10, 3'b000, 2'd0, 5'd0, 1'b1, 32'h0, 32'hFFFFFFFC, 1'b0, 32'h0);
        exp_instret++;
        chk("rd0_no_write", regwren_o, 0);
        repeat (3) @(negedge clk);
        chk("instret_rd0", instret_o, instret_exp(exp_instret));

        // flushed load, stale response drained, new LW
        send(2'b01, 3'b010, 2'd0, 5'd9, 1'b1, 32'h0, 32'h10C, 1'b0, 32'h0);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_ready_low", ready_o, 0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        rsp(32'hDEADBEEF);
        exp_q.push_back({5'd10, 32'hCAFEF00D});
        send(2'b01, 3'b010, 2'd0, 5'd10, 1'b1, 32'h0, 32'h110, 1'b0, 32'h0);
        rsp(32'hCAFEF00D);
        exp_instret++;
        repeat (2) @(negedge clk);
        chk("drain_no_err", err_o, 0);

        // stray response sets sticky error
        rsp(32'h00000001);
        @(negedge clk);
        chk("stray_err", err_o, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err_o, 1);

        // asynchronous reset while a load waits
        send(2'b01, 3'b010, 2'd0, 5'd11, 1'b1, 32'h0, 32'h114, 1'b0, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", {rd_o, datawb_o, regwren_o, fwd_valid_o, fwd_rd_o, fwd_data_o, err_o}, 0);
        chk("async_rst_instret", instret_o, 0);
        chk("async_rst_ready", ready_o, 0);
        exp_instret = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_idle_ready", ready_o, 1);
        rsp(32'h12345678);
        @(negedge clk);
        chk("post_rst_rsp_err", err_o, 1);

        // ten back-to-back ALU ops
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({5'(i + 1), 32'hA000 + 32'(i)});
            send(2'b00, 3'b000, 2'd0, 5'(i + 1), 1'b1, 32'hA000 + 32'(i), 32'h200, 1'b0, 32'h0);
            exp_instret++;
            chk("b2b_pulse", regwren_o, 1);
        end
        repeat (2) @(negedge clk);
        chk("b2b_end", regwren_o, 0);
        repeat (2) @(negedge clk);
        chk("instret_b2b", instret_o, instret_exp(exp_instret));
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
